// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon 32/64 byte-serial front end.
package simon_pkg;

  localparam int SIMON_KEY_BYTES   = 8;
  localparam int SIMON_PT_BYTES    = 4;
  localparam int SIMON_KEY_W       = 64;
  localparam int SIMON_BLK_W       = 32;
  localparam int SIMON_FRAME_BYTES = SIMON_KEY_BYTES + SIMON_PT_BYTES;
  localparam int SIMON_FRAME_W     = SIMON_KEY_W + SIMON_BLK_W;
  localparam int SIMON_CT_BYTES    = SIMON_BLK_W / 8;

  // LOAD: collecting frame bytes; START: one-cycle core kick;
  // WAIT: waiting on core done (with watchdog); SEND: streaming ciphertext.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

endpackage

// File: rtl/simon_byte_if_if.sv
// Bus bundle between the byte-serial front end, its byte streams and the core.
//
// Handshake rule for both byte streams: a byte moves on a rising clock edge
// exactly when valid and ready are both high in that cycle. The producer holds
// the byte stable while valid is high and ready is low; ready may be high
// without valid (no transfer).
interface simon_byte_if_if;
  import simon_pkg::*;

  logic [7:0]             din;
  logic                   din_valid;
  logic                   din_ready;
  logic [7:0]             dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   core_start;
  logic [SIMON_KEY_W-1:0] core_key;
  logic [SIMON_BLK_W-1:0] core_pt;
  logic [SIMON_BLK_W-1:0] core_ct;
  logic                   core_done;
  logic                   busy;
  logic                   err;

  // The front end itself.
  modport slave (
    input  din, din_valid, dout_ready, core_ct, core_done,
    output din_ready, dout, dout_valid, core_start, core_key, core_pt, busy, err
  );

  // Everything around it: byte source/sink plus the core.
  modport master (
    output din, din_valid, dout_ready, core_ct, core_done,
    input  din_ready, dout, dout_valid, core_start, core_key, core_pt, busy, err
  );

endinterface

// File: rtl/simon_byte_if.sv
// Byte-serial front end for the Simon 32/64 core: assembles a 12-byte frame
// (key then plaintext, MSB first), kicks the core, waits for done under a
// watchdog and streams the 4 ciphertext bytes back out.
module simon_byte_if
  import simon_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  simon_byte_if_if.slave  bus,
  output state_t          o_dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [3:0]               r_in_cnt;
  logic [1:0]               r_out_cnt;
  logic                     r_armed;
  logic [WD_W-1:0]          r_wd_cnt;
  logic [SIMON_FRAME_W-1:0] r_shift;
  logic [23:0]              r_ct;
  logic [7:0]               r_dout;
  logic                     r_start;
  logic                     r_err;

  logic                     w_in_acc;
  logic                     w_out_acc;
  logic                     w_last_in;
  logic                     w_last_out;
  logic                     w_capture;
  logic                     w_timeout;
  logic [WD_W-1:0]          w_wd_inc;

  assign w_in_acc   = (r_state == LOAD) && bus.din_valid;
  assign w_out_acc  = (r_state == SEND) && bus.dout_ready;
  assign w_last_in  = (r_in_cnt == 4'(SIMON_FRAME_BYTES - 1));
  assign w_last_out = (r_out_cnt == 2'(SIMON_CT_BYTES - 1));
  // The first WAIT cycle only arms; a done left high by the previous
  // operation must not be mistaken for this one.
  assign w_capture  = (r_state == WAIT) && r_armed && bus.core_done;
  assign w_wd_inc   = r_wd_cnt + WD_W'(1);
  // done wins over a simultaneous timeout.
  assign w_timeout  = (r_state == WAIT) && r_armed && !bus.core_done &&
                      (w_wd_inc == WD_W'(TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      LOAD:    if (w_in_acc && w_last_in) w_state_nxt = START;
      START:   w_state_nxt = WAIT;
      WAIT: begin
        if (w_capture)      w_state_nxt = SEND;
        else if (w_timeout) w_state_nxt = LOAD;
      end
      SEND:    if (w_out_acc && w_last_out) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  // Input frame: shift bytes in MSB first and count them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift  <= '0;
      r_in_cnt <= '0;
    end else if (w_in_acc) begin
      r_shift  <= {r_shift[SIMON_FRAME_W-9:0], bus.din};
      r_in_cnt <= w_last_in ? 4'd0 : r_in_cnt + 4'd1;
    end
  end

  // Start pulse lands in the single START cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_start <= 1'b0;
    else        r_start <= w_in_acc && w_last_in;
  end

  // Arm flag and watchdog counter, both cleared on the way into WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed  <= 1'b0;
      r_wd_cnt <= '0;
    end else if (r_state == START) begin
      r_armed  <= 1'b0;
      r_wd_cnt <= '0;
    end else if (r_state == WAIT) begin
      if (!r_armed)              r_armed  <= 1'b1;
      else if (!bus.core_done)   r_wd_cnt <= w_wd_inc;
    end
  end

  // Sticky timeout flag; the first byte of the next frame clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_err <= 1'b0;
    else if (w_timeout)                  r_err <= 1'b1;
    else if (w_in_acc && r_in_cnt == '0) r_err <= 1'b0;
  end

  // Ciphertext capture and byte-by-byte output; r_dout holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ct      <= '0;
      r_dout    <= '0;
      r_out_cnt <= '0;
    end else if (w_capture) begin
      r_ct      <= bus.core_ct[23:0];
      r_dout    <= bus.core_ct[31:24];
      r_out_cnt <= '0;
    end else if (w_out_acc) begin
      r_ct      <= {r_ct[15:0], 8'h00};
      r_dout    <= r_ct[23:16];
      r_out_cnt <= r_out_cnt + 2'd1;
    end
  end

  assign bus.din_ready  = (r_state == LOAD);
  assign bus.dout_valid = (r_state == SEND);
  assign bus.busy       = (r_state != LOAD);
  assign bus.dout       = r_dout;
  assign bus.core_start = r_start;
  assign bus.core_key   = r_shift[SIMON_FRAME_W-1:SIMON_BLK_W];
  assign bus.core_pt    = r_shift[SIMON_BLK_W-1:0];
  assign bus.err        = r_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_simon_byte_if.sv
// Directed bench for simon_byte_if with a behavioural core stand-in that
// answers known key/plaintext pairs from a lookup table.
module tb_simon_byte_if;
  import simon_pkg::*;

  localparam int TIMEOUT  = 64;
  localparam int M_NORMAL = 0;
  localparam int M_STALE  = 1;
  localparam int M_NEVER  = 2;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;
  always #5 clk = ~clk;

  simon_byte_if_if bus();

  simon_byte_if #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  logic [95:0] frame_tab[3];
  logic [31:0] ct_tab[3];

  // ---------------- core stand-in ----------------
  int          core_mode = M_NORMAL;
  int          core_lat  = 32;
  int          core_cnt  = 0;
  bit          core_active = 1'b0;
  logic [95:0] core_frame;

  function automatic logic [31:0] lookup(input logic [95:0] f);
    for (int i = 0; i < 3; i++)
      if (f === frame_tab[i]) return ct_tab[i];
    return 32'hbad0bad0;
  endfunction

  always @(negedge clk) begin
    if (bus.core_start) begin
      core_frame  = {bus.core_key, bus.core_pt};
      core_cnt    = 0;
      core_active = 1'b1;
      if (core_mode == M_STALE) begin
        bus.core_done = 1'b1;
        bus.core_ct   = 32'h0badf00d;
      end else begin
        bus.core_done = 1'b0;
      end
    end else if (core_active) begin
      core_cnt++;
      if (core_mode == M_NORMAL && core_cnt == core_lat) begin
        bus.core_done = 1'b1;
        bus.core_ct   = lookup(core_frame);
        core_active   = 1'b0;
      end else if (core_mode == M_STALE && core_cnt == 2) begin
        bus.core_done = 1'b0;
      end else if (core_mode == M_STALE && core_cnt == 12) begin
        bus.core_done = 1'b1;
        bus.core_ct   = lookup(core_frame);
        core_active   = 1'b0;
      end
    end
  end

  // Event monitors sampled on the active edge.
  int start_cnt = 0;
  int dv_cnt    = 0;
  always @(posedge clk) begin
    if (bus.core_start) start_cnt++;
    if (bus.dout_valid) dv_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_din_ready",  bus.din_ready,  1'b1);
    check("rst_dout",       bus.dout,       8'h00);
    check("rst_dout_valid", bus.dout_valid, 1'b0);
    check("rst_core_start", bus.core_start, 1'b0);
    check("rst_core_key",   bus.core_key,   64'h0);
    check("rst_core_pt",    bus.core_pt,    32'h0);
    check("rst_busy",       bus.busy,       1'b0);
    check("rst_err",        bus.err,        1'b0);
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.din_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.din       = b;
    bus.din_valid = 1'b1;
    t = 0;
    while (!bus.din_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("din_ready_timeout", bus.din_ready, 1'b1);
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic send_bytes(input int idx, input int from, input int to, input bit rnd);
    logic [95:0] f;
    f = frame_tab[idx];
    for (int i = from; i <= to; i++)
      send_byte(f[95-8*i -: 8], rnd ? int'($urandom_range(0, 5)) : 0);
  endtask

  // Ends in the cycle right after the 12th accept (the START cycle).
  task automatic send_frame(input int idx, input bit rnd);
    logic [95:0] f;
    f = frame_tab[idx];
    send_bytes(idx, 0, 11, rnd);
    check("start_pulse", bus.core_start, 1'b1);
    check("core_key",    bus.core_key,   f[95:32]);
    check("core_pt",     bus.core_pt,    f[31:0]);
    check("busy_start",  bus.busy,       1'b1);
    exp_q.push_back(ct_tab[idx]);
  endtask

  task automatic wait_dout_valid(output int n);
    n = 0;
    while (!bus.dout_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic recv_byte(input logic [7:0] exp, input int stall);
    int          t;
    logic [7:0]  held;
    wait_dout_valid(t);
    check("dout_valid", bus.dout_valid, 1'b1);
    held = bus.dout;
    repeat (stall) begin
      @(negedge clk);
      check("dout_stable", {bus.dout_valid, bus.dout}, {1'b1, held});
    end
    check("dout_byte", bus.dout, exp);
    bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.dout_ready = 1'b0;
  endtask

  task automatic recv_frame(input bit rnd);
    logic [31:0] c;
    c = exp_q.pop_front();
    for (int k = 0; k < 4; k++)
      recv_byte(c[31-8*k -: 8], rnd ? int'($urandom_range(0, 5)) : 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    int          s0;
    int          d0;
    logic [31:0] c;

    frame_tab[0] = 96'h1918111009080100_65656877; ct_tab[0] = 32'hc69be9bb;
    frame_tab[1] = 96'hae4f4b3f2bea21bb_b94dd41b; ct_tab[1] = 32'h8494f458;
    frame_tab[2] = 96'h0123456789abcdef_deadbeef; ct_tab[2] = 32'h3c5a96e1;

    bus.din        = 8'h00;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    bus.core_ct    = 32'h0;
    bus.core_done  = 1'b0;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    @(negedge clk);

    // Reference vector, no gaps, 32-cycle core, consumer always ready.
    core_mode = M_NORMAL;
    core_lat  = 32;
    s0 = start_cnt;
    send_frame(0, 1'b0);
    wait_dout_valid(n);
    check("latency_l32", n, 33);
    c = exp_q.pop_front();
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("burst_valid", bus.dout_valid, 1'b1);
      check("burst_byte",  bus.dout,       c[31-8*k -: 8]);
      @(negedge clk);
    end
    bus.dout_ready = 1'b0;
    check("ready_after_send", bus.din_ready, 1'b1);
    check("idle_after_send",  bus.busy,      1'b0);
    check("one_start_pulse",  start_cnt - s0, 1);

    // Gapped input, junk din_valid while busy, stalled output.
    core_lat = 9;
    send_frame(1, 1'b1);
    @(negedge clk);
    bus.din       = 8'ha5;
    bus.din_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("junk_not_ready", bus.din_ready, 1'b0);
      check("key_hold_wait",  bus.core_key,  frame_tab[1][95:32]);
      @(negedge clk);
    end
    recv_frame(1'b1);
    bus.din_valid = 1'b0;
    check("load_after_junk", dbg_state, LOAD);

    // Stale done from the previous op must not be captured.
    core_mode = M_STALE;
    send_frame(2, 1'b0);
    wait_dout_valid(n);
    check("latency_stale", n, 13);
    recv_frame(1'b0);
    core_mode = M_NORMAL;

    // Earliest possible done sample.
    core_lat = 2;
    send_frame(0, 1'b1);
    wait_dout_valid(n);
    check("latency_min", n, 3);
    recv_frame(1'b1);

    // Watchdog: core never finishes.
    core_mode = M_NEVER;
    d0 = dv_cnt;
    send_frame(1, 1'b0);
    void'(exp_q.pop_back());
    repeat (65) @(negedge clk);
    check("wd_err_pre",   bus.err,   1'b0);
    check("wd_state_pre", dbg_state, WAIT);
    @(negedge clk);
    check("wd_err",       bus.err,       1'b1);
    check("wd_din_ready", bus.din_ready, 1'b1);
    check("wd_busy",      bus.busy,      1'b0);
    check("wd_no_dout",   dv_cnt - d0,   0);
    repeat (3) @(negedge clk);
    check("wd_err_sticky", bus.err, 1'b1);
    core_mode = M_NORMAL;
    core_lat  = 5;
    send_bytes(0, 0, 0, 1'b0);
    check("err_cleared", bus.err, 1'b0);
    send_bytes(0, 1, 11, 1'b0);
    check("wd_next_start", bus.core_start, 1'b1);
    exp_q.push_back(ct_tab[0]);
    recv_frame(1'b0);

    // Asynchronous reset after 7 input bytes.
    send_bytes(1, 0, 6, 1'b0);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_frame(1, 1'b1);
    recv_frame(1'b1);

    // Asynchronous reset in SEND after 2 output bytes.
    core_lat = 32;
    send_frame(0, 1'b0);
    c = exp_q.pop_front();
    recv_byte(c[31:24], 0);
    recv_byte(c[23:16], 0);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_frame(2, 1'b1);
    recv_frame(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_byte_if.md
# simon_byte_if

Byte-serial I/O front end for the Simon 32/64 core `simon_newer`; sits directly upstream and downstream of it on the chip top level. It accepts a 12-byte frame (8 key bytes, then 4 plaintext bytes) over a narrow valid/ready bus and assembles it into the core's parallel `key`/`plain_text`. It then pulses the core's `start` and waits for `done`. The 32-bit ciphertext is returned as 4 bytes on a second valid/ready bus, and a watchdog reports a core that never finishes.

## Interface
- `TIMEOUT`, 64: max WAIT cycles before error; legal range 4..1023.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `din`  in  8  input byte.
- `din_valid`  in  1  `din` valid.
- `din_ready`  out  1  block accepts a byte this cycle.
- `dout`  out  8  ciphertext byte.
- `dout_valid`  out  1  `dout` valid.
- `dout_ready`  in  1  consumer accepts `dout`.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_key`  out  64  key to the core.
- `core_pt`  out  32  plaintext to the core.
- `core_ct`  in  32  core `cipher_text`.
- `core_done`  in  1  core `done`.
- `busy`  out  1  high in START/WAIT/SEND.
- `err`  out  1  sticky timeout flag.

## Operation
- States:
  - LOAD: `din_ready`=1; byte counter 0..11.
  - START.
  - WAIT: sub-flag `armed`, plus watchdog counter of width clog2(TIMEOUT+1).
  - SEND: byte counter 0..3.
- LOAD:
  - Each accepted byte (`din_valid`&`din_ready`) shifts in MSB-first.
  - Bytes 0–7 go to `core_key[63:0]` (byte 0 → [63:56]); bytes 8–11 go to `core_pt` (byte 8 → [31:24]).
  - The 12th accept → START.
  - Acceptance of byte 0 clears `err`.
- START: `core_start`=1 for exactly one cycle → WAIT with `armed`=0 and counter=0.
- WAIT:
  - First cycle: sets `armed`=1 and ignores `core_done`, because a stale `done` from the previous operation may still be high.
  - Armed cycle with `core_done`=1: capture `core_ct` into the output register → SEND.
  - Otherwise increment the counter. Counter==TIMEOUT → `err`=1, discard the frame, → LOAD.
  - `core_done` and timeout in the same cycle: `done` wins and the frame is sent normally.
- SEND:
  - `dout_valid`=1; `dout` = captured ct byte [31:24], [23:16], [15:8], [7:0] in order.
  - Advance on `dout_valid`&`dout_ready`; `dout` is stable while stalled.
  - The 4th accept → LOAD.
- `core_key`/`core_pt` hold their values from START until the next LOAD byte overwrites them. They never change during WAIT.
- `din_valid` outside LOAD: ignored (`din_ready`=0), no state change.
- Reset assertion at any time:
  - State → LOAD, all counters 0, partial frame discarded.
  - Outputs: `din_ready`=1 (state LOAD); `dout`=0, `dout_valid`=0, `core_start`=0, `core_key`=0, `core_pt`=0, `busy`=0, `err`=0.

## Timing
- Unlike `core_start`/`dout`, which are registered outputs, `din_ready`, `dout_valid` and `busy` are decoded from registered state. No combinational path from any input to any output.
- 12th input accept at edge N:
  - `core_start`=1 in cycle N+1.
  - WAIT begins N+2; `core_done` is first sampled at N+3.
- `core_done` sampled high at edge M → `dout_valid`=1 from cycle M+1.
- Best-case return:
  - 4 output bytes in 4 consecutive cycles when `dout_ready` is held high.
  - After the 4th `dout` accept, `din_ready`=1 the following cycle.
- Back-to-back throughput: 12 + 2 + core latency + 4 cycles per block.

## Structure
- Shared package `simon_pkg`:
  - state enum {LOAD, START, WAIT, SEND};
  - constants `SIMON_KEY_BYTES`=8, `SIMON_PT_BYTES`=4, `SIMON_KEY_W`=64, `SIMON_BLK_W`=32.
- Single module; no sub-module. The 96-bit input shift register and 32-bit output register live inline.
- `simon_newer` is instantiated beside it in the chip top `simon_chip_top`, not inside it.

## Test plan
- Core model with 32-cycle latency; send bytes 19 18 11 10 09 08 01 00 65 65 68 77.
  - `core_key`=1918111009080100, `core_pt`=65656877 at START.
  - Exactly one `core_start` pulse.
  - `dout` = c6 9b e9 bb.
- Real `simon_newer`, all five vectors streamed back to back. Ciphertexts must be c69be9bb, 8494f458, deb4c76b, fc29a459, 32294659 (keys ae4f4b3f2bea21bb / pt b94dd41b → 8494f458, etc.), and each result must be streamed back before the next frame is accepted.
- Random `din_valid` gaps and `dout_ready` stalls of 0–5 cycles:
  - same ciphertext bytes;
  - `dout` stable during stalls;
  - `din_valid` pulses during WAIT/SEND ignored.
- Stale `done`: `core_done` held high through START and the first WAIT cycle, then low for 10 cycles, then high. Capture happens only on the later rising-done cycle.
- Watchdog: `core_done` never asserted, TIMEOUT=64.
  - `err`=1 exactly 64 WAIT cycles after arming; no `dout_valid`; state returns to LOAD.
  - Next frame's first byte clears `err`.
- Reset: `reset`=0 pulsed after 7 input bytes, and again during SEND after 2 output bytes.
  - All outputs go to their reset values immediately (asynchronously).
  - A fresh full frame afterwards produces correct ciphertext.
